flash_arbiter: RTL

FLASH_ARBITER -- requirements
Module: flash_arbiter

---
 rtl/flash_arbiter_if.sv | 36 +++
 rtl/flash_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/flash_arbiter_if.sv
// Requester-side bus of flash_arbiter: per-requester read requests and the shared
// read-data return path.
interface flash_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LEN_W   = 12
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*24-1:0]    req_addr;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;
  logic [7:0]               rd_data;
  logic [NUM_REQ-1:0]       rd_valid;
  logic [NUM_REQ-1:0]       rd_last;

  modport master (
    output req_valid,
    output req_addr,
    output req_len,
    input  req_ready,
    input  rd_data,
    input  rd_valid,
    input  rd_last
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_len,
    output req_ready,
    output rd_data,
    output rd_valid,
    output rd_last
  );

endinterface

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one flash_reader between NUM_REQ read requesters.
// One request at a time: START kicks the reader, STREAM forwards bytes, DRAIN stops it.
module flash_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LEN_W   = 12
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  flash_arbiter_if.slave bus,
  output logic           o_busy,
  output logic [23:0]    o_fl_addr,
  output logic           o_fl_start_read,
  output logic           o_fl_keep_reading,
  input  logic [7:0]     i_fl_data,
  input  logic           i_fl_data_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StStart, StStream, StDrain} state_e;

  state_e               r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_win;
  logic [LEN_W:0]       r_remain;
  logic [23:0]          r_fl_addr;
  logic                 r_fl_start_read;
  logic                 r_fl_keep_reading;
  logic                 r_busy;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_rd_valid;
  logic [NUM_REQ-1:0]   r_rd_last;
  logic [7:0]           r_rd_data;

  logic                 w_found;
  logic [IDX_W-1:0]     w_win;
  logic [IDX_W:0]       w_idx;
  logic [IDX_W-1:0]     w_next_ptr;
  logic [LEN_W-1:0]     w_len;
  logic [LEN_W:0]       w_len_load;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [NUM_REQ-1:0]   w_cur_oh;

  // Scan from the pointer upward, wrapping, so the requester after the last winner goes first.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_idx >= (IDX_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_found && bus.req_valid[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDX_W-1:0];
      end
    end
  end

  assign w_next_ptr = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_len      = bus.req_len[LEN_W*w_win +: LEN_W];
  // A zero length encodes the full 2^LEN_W bytes.
  assign w_len_load = (w_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_len};
  assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_cur_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= StIdle;
      r_rr_ptr          <= '0;
      r_win             <= '0;
      r_remain          <= '0;
      r_fl_addr         <= '0;
      r_fl_start_read   <= 1'b0;
      r_fl_keep_reading <= 1'b0;
      r_busy            <= 1'b0;
      r_req_ready       <= '0;
      r_rd_valid        <= '0;
      r_rd_last         <= '0;
      r_rd_data         <= '0;
    end else begin
      r_req_ready <= '0;
      r_rd_valid  <= '0;
      r_rd_last   <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_win             <= w_win;
            r_rr_ptr          <= w_next_ptr;
            r_fl_addr         <= bus.req_addr[24*w_win +: 24];
            r_remain          <= w_len_load;
            r_req_ready       <= w_grant_oh;
            r_fl_start_read   <= 1'b1;
            r_fl_keep_reading <= 1'b0;
            r_busy            <= 1'b1;
            r_state           <= StStart;
          end
        end
        StStart: begin
          r_fl_start_read   <= 1'b0;
          r_fl_keep_reading <= 1'b1;
          r_state           <= StStream;
        end
        StStream: begin
          if (i_fl_data_ready) begin
            r_rd_data  <= i_fl_data;
            r_rd_valid <= w_cur_oh;
            r_remain   <= r_remain - 1'b1;
            if (r_remain == (LEN_W+1)'(1)) begin
              r_rd_last         <= w_cur_oh;
              r_fl_keep_reading <= 1'b0;
              r_state           <= StDrain;
            end
          end
        end
        StDrain: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.rd_data        = r_rd_data;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.rd_last        = r_rd_last;
  assign o_busy             = r_busy;
  assign o_fl_addr          = r_fl_addr;
  assign o_fl_start_read    = r_fl_start_read;
  assign o_fl_keep_reading  = r_fl_keep_reading;

endmodule
